// File: rtl/maze_game_pkg.sv
// Shared definitions for the maze-game controller: FSM state encodings, difficulty codes,
// button indices and one-hot button selections.
package maze_game_pkg;

  typedef enum logic [2:0] {
    StMenu  = 3'd0,
    StShow  = 3'd1,
    StPlay  = 3'd2,
    StCheck = 3'd3,
    StLost  = 3'd4,
    StWon   = 3'd5
  } state_e;

  localparam logic [1:0] DiffEasy = 2'd0;
  localparam logic [1:0] DiffMed  = 2'd1;
  localparam logic [1:0] DiffHard = 2'd2;

  localparam int unsigned BtnUp    = 0;
  localparam int unsigned BtnDown  = 1;
  localparam int unsigned BtnLeft  = 2;
  localparam int unsigned BtnRight = 3;

  // Winning button after priority resolution (up > down > left > right).
  localparam logic [3:0] SelNone  = 4'b0000;
  localparam logic [3:0] SelUp    = 4'b0001;
  localparam logic [3:0] SelDown  = 4'b0010;
  localparam logic [3:0] SelLeft  = 4'b0100;
  localparam logic [3:0] SelRight = 4'b1000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Controller-side bundle: button pulses and map ROM data in, ROM address, player position and
// game status out.
//   master: the controller (drives map_addr, player_x/y, game_state, difficulty, flags)
//   slave : the surrounding logic (drives SCENs, map_row)
interface maze_game_ctrl_if #(
  parameter int unsigned MAP_W = 30,
  parameter int unsigned MAP_H = 21
);
  logic [3:0]                 SCENs;
  logic [MAP_W-1:0]           map_row;
  logic [$clog2(MAP_H)-1:0]   map_addr;
  logic [$clog2(MAP_W)-1:0]   player_x;
  logic [$clog2(MAP_H)-1:0]   player_y;
  logic [2:0]                 game_state;
  logic [1:0]                 difficulty;
  logic                       map_visible;
  logic                       lost;
  logic                       won;

  modport master (
    input  SCENs, map_row,
    output map_addr, player_x, player_y, game_state, difficulty, map_visible, lost, won
  );

  modport slave (
    output SCENs, map_row,
    input  map_addr, player_x, player_y, game_state, difficulty, map_visible, lost, won
  );
endinterface

// File: rtl/maze_game_ctrl_preview_timer.sv
// Loadable down-counter timing the map preview.
//   clk, reset : clock, synchronous active-high reset (count cleared)
//   load       : load count with value
//   value      : preview length in cycles
//   done       : high during the last counted cycle (count == 1)
module maze_game_ctrl_preview_timer #(
  parameter int unsigned CntW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] value,
  output logic            done
);
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign done = (cnt_q == CntW'(1));
endmodule

// File: rtl/maze_game_ctrl.sv
// Maze-game controller: menu with difficulty select, timed map preview, player movement,
// wall check against a 1-cycle-latency row ROM, and goal detection.
//   clk, reset : clock, synchronous active-high reset
//   bus        : maze_game_ctrl_if master (buttons/ROM data in, position/status out)
module maze_game_ctrl
  import maze_game_pkg::*;
#(
  parameter int unsigned MAP_W     = 30,
  parameter int unsigned MAP_H     = 21,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 20,
  parameter int unsigned GOAL_X    = 29,
  parameter int unsigned GOAL_Y    = 0,
  parameter int unsigned SHOW_EASY = 50_000_000,
  parameter int unsigned SHOW_MED  = 25_000_000,
  parameter int unsigned SHOW_HARD = 10_000_000
) (
  input logic               clk,
  input logic               reset,
  maze_game_ctrl_if.master  bus
);
  localparam int unsigned XW   = $clog2(MAP_W);
  localparam int unsigned YW   = $clog2(MAP_H);
  localparam int unsigned CntW = $clog2(max3(SHOW_EASY, SHOW_MED, SHOW_HARD)) + 1;

  state_e          state_q;
  logic [1:0]      diff_q;
  logic [XW-1:0]   px_q;
  logic [YW-1:0]   py_q;
  logic [YW-1:0]   addr_q;
  logic            vis_q, lost_q, won_q;
  logic            chk_q;  // second CHECK cycle: ROM data for the new row is valid

  logic [3:0]      sel;
  logic [XW-1:0]   nx;
  logic [YW-1:0]   ny;
  logic            legal;
  logic [CntW-1:0] show_val;
  logic            start_game;
  logic            show_done;

  // Priority-resolve simultaneous pulses to a one-hot selection.
  always_comb begin
    sel           = SelNone;
    sel[BtnUp]    = bus.SCENs[BtnUp];
    sel[BtnDown]  = bus.SCENs[BtnDown] & ~bus.SCENs[BtnUp];
    sel[BtnLeft]  = bus.SCENs[BtnLeft] & ~(|bus.SCENs[1:0]);
    sel[BtnRight] = bus.SCENs[BtnRight] & ~(|bus.SCENs[2:0]);
  end

  // Candidate position; edge checks done on the current position so nothing wraps.
  always_comb begin
    nx    = px_q;
    ny    = py_q;
    legal = 1'b0;
    unique case (sel)
      SelUp: begin
        legal = (py_q != '0);
        ny    = py_q - YW'(1);
      end
      SelDown: begin
        legal = (py_q != YW'(MAP_H - 1));
        ny    = py_q + YW'(1);
      end
      SelLeft: begin
        legal = (px_q != '0);
        nx    = px_q - XW'(1);
      end
      SelRight: begin
        legal = (px_q != XW'(MAP_W - 1));
        nx    = px_q + XW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (diff_q)
      DiffMed:  show_val = CntW'(SHOW_MED);
      DiffHard: show_val = CntW'(SHOW_HARD);
      default:  show_val = CntW'(SHOW_EASY);
    endcase
  end

  assign start_game = (state_q == StMenu) && (sel == SelRight);

  maze_game_ctrl_preview_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start_game),
    .value (show_val),
    .done  (show_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StMenu;
      diff_q  <= DiffEasy;
      px_q    <= XW'(START_X);
      py_q    <= YW'(START_Y);
      addr_q  <= YW'(START_Y);
      vis_q   <= 1'b0;
      lost_q  <= 1'b0;
      won_q   <= 1'b0;
      chk_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StMenu: begin
          if (sel == SelUp && diff_q != DiffEasy) begin
            diff_q <= diff_q - 2'd1;
          end else if (sel == SelDown && diff_q != DiffHard) begin
            diff_q <= diff_q + 2'd1;
          end else if (start_game) begin
            state_q <= StShow;
            px_q    <= XW'(START_X);
            py_q    <= YW'(START_Y);
            addr_q  <= YW'(START_Y);
            lost_q  <= 1'b0;
            won_q   <= 1'b0;
            vis_q   <= 1'b1;
          end
        end
        StShow: begin
          if (show_done) begin
            state_q <= StPlay;
            vis_q   <= 1'b0;
          end
        end
        StPlay: begin
          if (legal) begin
            px_q    <= nx;
            py_q    <= ny;
            addr_q  <= ny;
            chk_q   <= 1'b0;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (!chk_q) begin
            chk_q <= 1'b1;
          end else begin
            chk_q <= 1'b0;
            // Wall wins over goal if the map marks the goal as a wall.
            if (bus.map_row[px_q]) begin
              state_q <= StLost;
              lost_q  <= 1'b1;
              vis_q   <= 1'b1;
            end else if (px_q == XW'(GOAL_X) && py_q == YW'(GOAL_Y)) begin
              state_q <= StWon;
              won_q   <= 1'b1;
              vis_q   <= 1'b1;
            end else begin
              state_q <= StPlay;
            end
          end
        end
        StLost, StWon: begin
          if (|bus.SCENs) begin
            state_q <= StMenu;
            vis_q   <= 1'b0;
          end
        end
        default: state_q <= StMenu;
      endcase
    end
  end

  assign bus.map_addr    = addr_q;
  assign bus.player_x    = px_q;
  assign bus.player_y    = py_q;
  assign bus.game_state  = state_q;
  assign bus.difficulty  = diff_q;
  assign bus.map_visible = vis_q;
  assign bus.lost        = lost_q;
  assign bus.won         = won_q;
endmodule

// File: tb/tb_maze_game_ctrl.sv
// Bench for maze_game_ctrl on an 8x4 map with start (0,3), goal (7,0), preview 4/3/2 cycles.
module tb_maze_game_ctrl;
  import maze_game_pkg::*;

  localparam logic [3:0] N = 4'b0000;
  localparam logic [3:0] U = 4'b0001;
  localparam logic [3:0] D = 4'b0010;
  localparam logic [3:0] L = 4'b0100;
  localparam logic [3:0] R = 4'b1000;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] diff;
    logic [2:0] px;
    logic [1:0] py;
    logic [1:0] addr;
    logic       vis;
    logic       lost;
    logic       won;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [3:0] scen;
    obs_t       exp;
  } vec_t;

  logic clk;
  logic reset;
  logic [7:0] rom [4];
  vec_t vecs[$];
  obs_t sb[$];
  int total;
  int bad;

  maze_game_ctrl_if #(.MAP_W(8), .MAP_H(4)) bus ();

  maze_game_ctrl #(
    .MAP_W     (8),
    .MAP_H     (4),
    .START_X   (0),
    .START_Y   (3),
    .GOAL_X    (7),
    .GOAL_Y    (0),
    .SHOW_EASY (4),
    .SHOW_MED  (3),
    .SHOW_HARD (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM, one cycle read latency. Bit x set = wall at column x.
  always @(posedge clk) bus.map_row <= rom[bus.map_addr];

  function automatic obs_t mk(input state_e st, input int d, input int x, input int y,
                              input bit v, input bit l, input bit w);
    obs_t o;
    o.st   = st;
    o.diff = 2'(d);
    o.px   = 3'(x);
    o.py   = 2'(y);
    o.addr = 2'(y);
    o.vis  = v;
    o.lost = l;
    o.won  = w;
    return o;
  endfunction

  task automatic add(input logic rst, input logic [3:0] scen, input obs_t e);
    vec_t v;
    v.rst  = rst;
    v.scen = scen;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input logic rst, input logic [3:0] scen, input obs_t e, input int idx);
    obs_t got;
    obs_t want;
    reset     = rst;
    bus.SCENs = scen;
    sb.push_back(e);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.SCENs = N;
    got.st   = bus.game_state;
    got.diff = bus.difficulty;
    got.px   = bus.player_x;
    got.py   = bus.player_y;
    got.addr = bus.map_addr;
    got.vis  = bus.map_visible;
    got.lost = bus.lost;
    got.won  = bus.won;
    want = sb.pop_front();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL step%0d: got st=%0d diff=%0d x=%0d y=%0d addr=%0d vis=%b lost=%b won=%b; want st=%0d diff=%0d x=%0d y=%0d addr=%0d vis=%b lost=%b won=%b",
               idx, got.st, got.diff, got.px, got.py, got.addr, got.vis, got.lost, got.won,
               want.st, want.diff, want.px, want.py, want.addr, want.vis, want.lost, want.won);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rom[0] = 8'b0000_0000;
    rom[1] = 8'b1111_1101;
    rom[2] = 8'b1111_1101;
    rom[3] = 8'b1111_0100;
    reset     = 1'b1;
    bus.SCENs = N;

    // Menu: reset, saturating difficulty select.
    add(1, N, mk(StMenu, 0, 0, 3, 0, 0, 0));
    add(0, U, mk(StMenu, 0, 0, 3, 0, 0, 0));
    add(0, D, mk(StMenu, 1, 0, 3, 0, 0, 0));
    add(0, D, mk(StMenu, 2, 0, 3, 0, 0, 0));
    add(0, D, mk(StMenu, 2, 0, 3, 0, 0, 0));
    add(0, U, mk(StMenu, 1, 0, 3, 0, 0, 0));
    add(0, D, mk(StMenu, 2, 0, 3, 0, 0, 0));
    // Hard preview: exactly two visible cycles.
    add(0, R, mk(StShow, 2, 0, 3, 1, 0, 0));
    add(0, N, mk(StShow, 2, 0, 3, 1, 0, 0));
    add(0, N, mk(StPlay, 2, 0, 3, 0, 0, 0));
    // Edge moves dropped, then a legal move through CHECK.
    add(0, L, mk(StPlay, 2, 0, 3, 0, 0, 0));
    add(0, D, mk(StPlay, 2, 0, 3, 0, 0, 0));
    add(0, R, mk(StCheck, 2, 1, 3, 0, 0, 0));
    add(0, N, mk(StCheck, 2, 1, 3, 0, 0, 0));
    add(0, N, mk(StPlay, 2, 1, 3, 0, 0, 0));
    // Up+right applies only up; pulse during CHECK dropped.
    add(0, U | R, mk(StCheck, 2, 1, 2, 0, 0, 0));
    add(0, R, mk(StCheck, 2, 1, 2, 0, 0, 0));
    add(0, N, mk(StPlay, 2, 1, 2, 0, 0, 0));
    for (int y = 1; y >= 0; y--) begin
      add(0, U, mk(StCheck, 2, 1, y, 0, 0, 0));
      add(0, N, mk(StCheck, 2, 1, y, 0, 0, 0));
      add(0, N, mk(StPlay, 2, 1, y, 0, 0, 0));
    end
    add(0, U, mk(StPlay, 2, 1, 0, 0, 0, 0));
    // Walk along the top row to the goal.
    for (int x = 2; x <= 7; x++) begin
      add(0, R, mk(StCheck, 2, x, 0, 0, 0, 0));
      add(0, N, mk(StCheck, 2, x, 0, 0, 0, 0));
      if (x == 7) add(0, N, mk(StWon, 2, 7, 0, 1, 0, 1));
      else        add(0, N, mk(StPlay, 2, x, 0, 0, 0, 0));
    end
    add(0, N, mk(StWon, 2, 7, 0, 1, 0, 1));
    add(0, L, mk(StMenu, 2, 7, 0, 0, 0, 1));
    add(0, U, mk(StMenu, 1, 7, 0, 0, 0, 1));
    // Medium game: start clears won, preview 3 cycles ignoring pulses, then hit a wall.
    add(0, R, mk(StShow, 1, 0, 3, 1, 0, 0));
    add(0, D, mk(StShow, 1, 0, 3, 1, 0, 0));
    add(0, N, mk(StShow, 1, 0, 3, 1, 0, 0));
    add(0, N, mk(StPlay, 1, 0, 3, 0, 0, 0));
    add(0, R, mk(StCheck, 1, 1, 3, 0, 0, 0));
    add(0, N, mk(StCheck, 1, 1, 3, 0, 0, 0));
    add(0, N, mk(StPlay, 1, 1, 3, 0, 0, 0));
    add(0, R, mk(StCheck, 1, 2, 3, 0, 0, 0));
    add(0, N, mk(StCheck, 1, 2, 3, 0, 0, 0));
    add(0, N, mk(StLost, 1, 2, 3, 1, 1, 0));
    add(0, N, mk(StLost, 1, 2, 3, 1, 1, 0));
    add(0, R, mk(StMenu, 1, 2, 3, 0, 1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].rst, vecs[i].scen, vecs[i].exp, i);
    end

    // Reset asserted in the middle of CHECK aborts the game.
    apply(0, R, mk(StShow, 1, 0, 3, 1, 0, 0), 100);
    apply(0, N, mk(StShow, 1, 0, 3, 1, 0, 0), 101);
    apply(0, N, mk(StShow, 1, 0, 3, 1, 0, 0), 102);
    apply(0, N, mk(StPlay, 1, 0, 3, 0, 0, 0), 103);
    apply(0, R, mk(StCheck, 1, 1, 3, 0, 0, 0), 104);
    apply(1, N, mk(StMenu, 0, 0, 3, 0, 0, 0), 105);
    apply(0, N, mk(StMenu, 0, 0, 3, 0, 0, 0), 106);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
